// File: rtl/dfr_output_classifier.sv
// Scans the DFR output memory and writes the signed argmax of each sample's
// class scores, together with the winning score, into the class-result RAM.
module dfr_output_classifier #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SAMPLES = 100,
  parameter int NUM_CLASSES = 10,
  parameter int CLASS_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  score_addr,
  input  logic [DATA_WIDTH-1:0]  score_data,
  output logic [ADDR_WIDTH-1:0]  class_addr,
  output logic [CLASS_WIDTH-1:0] class_data,
  output logic [DATA_WIDTH-1:0]  class_score,
  output logic                   class_wen
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(NUM_SAMPLES * NUM_CLASSES - 1);
  localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(NUM_CLASSES - 1);

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  rd_cnt;
  logic [CLASS_WIDTH-1:0] iss_cls;
  logic [ADDR_WIDTH-1:0]  iss_smp;
  logic                   rv;
  logic [CLASS_WIDTH-1:0] rv_cls;
  logic [ADDR_WIDTH-1:0]  rv_smp;
  logic [DATA_WIDTH-1:0]  best_score;
  logic [CLASS_WIDTH-1:0] best_idx;
  logic [DATA_WIDTH-1:0]  cand_score;
  logic [CLASS_WIDTH-1:0] cand_idx;
  logic                   last_of_sample;

  // Issue side: one read address per cycle, (sample, class) tracked alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      iss_cls <= '0;
      iss_smp <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            rd_cnt  <= '0;
            iss_cls <= '0;
            iss_smp <= '0;
          end
        end
        S_RUN: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (iss_cls == LAST_CLASS) begin
            iss_cls <= '0;
            iss_smp <= iss_smp + 1'b1;
          end else begin
            iss_cls <= iss_cls + 1'b1;
          end
          if (rd_cnt == LAST_ADDR) state <= S_DRAIN;
        end
        // With at least two classes, the only write seen here is the final one.
        S_DRAIN: if (class_wen) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag the returning read data: the RAM answers one cycle after the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv     <= 1'b0;
      rv_cls <= '0;
      rv_smp <= '0;
    end else begin
      rv     <= (state == S_RUN);
      rv_cls <= iss_cls;
      rv_smp <= iss_smp;
    end
  end

  always_comb begin
    cand_score = best_score;
    cand_idx   = best_idx;
    if (rv_cls == '0) begin
      cand_score = score_data;
      cand_idx   = '0;
    end else if ($signed(score_data) > $signed(best_score)) begin
      cand_score = score_data;
      cand_idx   = rv_cls;
    end
  end

  assign last_of_sample = rv && (rv_cls == LAST_CLASS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score  <= '0;
      best_idx    <= '0;
      class_wen   <= 1'b0;
      class_addr  <= '0;
      class_data  <= '0;
      class_score <= '0;
    end else begin
      if (rv) begin
        best_score <= cand_score;
        best_idx   <= cand_idx;
      end
      class_wen <= last_of_sample;
      if (last_of_sample) begin
        class_addr  <= rv_smp;
        class_data  <= cand_idx;
        class_score <= cand_score;
      end
    end
  end

  assign score_addr = (state == S_RUN) ? rd_cnt : '0;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

endmodule
